// File: rtl/cache_control_if.sv
// Bus bundle between the cache controller and its CPU port, physical-memory port and datapath.
// master = the controller; slave = the datapath/memory side that drives the status inputs.
interface cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic hit0;
    logic hit1;
    logic dirty0;
    logic dirty1;
    logic lru;
    logic pmem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_addr_sel;
    logic way_sel;
    logic load_data;
    logic load_tag;
    logic load_valid;
    logic load_dirty;
    logic load_lru;
    logic data_in_sel;
    logic dirty_in;
    logic lru_in;

    modport master (
        input  mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
               load_data, load_tag, load_valid, load_dirty, load_lru,
               data_in_sel, dirty_in, lru_in
    );

    modport slave (
        output mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
               load_data, load_tag, load_valid, load_dirty, load_lru,
               data_in_sel, dirty_in, lru_in
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative write-back cache: hit, dirty-victim writeback, line fill.
// Optional hit/miss counters are enabled by defining CACHE_PERF_COUNTERS_EN.
module cache_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    cache_control_if.master bus
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
`endif
);

    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("cache_control: COUNT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic req;
    logic is_write;
    logic hit;
    logic hit_way;
    logic victim_dirty;
    logic hit_resp;

    assign req          = bus.mem_read | bus.mem_write;
    assign is_write     = bus.mem_write;
    assign hit          = bus.hit0 | bus.hit1;
    assign hit_way      = bus.hit1;
    assign victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;
    assign hit_resp     = (state == CHECK) && req && hit;

    always_comb begin
        next_state = state;
        case (state)
            CHECK: begin
                if (req && !hit) begin
                    next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (bus.pmem_resp) begin
                    next_state = CHECK;
                end
            end
            default: next_state = CHECK;
        endcase
    end

    // Outputs are forced low while rst is high so an in-flight memory cycle aborts immediately.
    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.way_sel       = 1'b0;
        bus.load_data     = 1'b0;
        bus.load_tag      = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_dirty    = 1'b0;
        bus.load_lru      = 1'b0;
        bus.data_in_sel   = 1'b0;
        bus.dirty_in      = 1'b0;
        bus.lru_in        = 1'b0;
        if (!rst) begin
            case (state)
                CHECK: begin
                    if (req && hit) begin
                        bus.mem_resp = 1'b1;
                        bus.way_sel  = hit_way;
                        bus.load_lru = 1'b1;
                        bus.lru_in   = ~hit_way;
                        if (is_write) begin
                            bus.load_data  = 1'b1;
                            bus.load_dirty = 1'b1;
                            bus.dirty_in   = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                    bus.way_sel       = bus.lru;
                end
                ALLOCATE: begin
                    bus.pmem_read = 1'b1;
                    bus.way_sel   = bus.lru;
                    if (bus.pmem_resp) begin
                        bus.load_data   = 1'b1;
                        bus.data_in_sel = 1'b1;
                        bus.load_tag    = 1'b1;
                        bus.load_valid  = 1'b1;
                        bus.load_dirty  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CHECK;
        end else begin
            state <= next_state;
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    logic refill;

    // refill marks the hit that completes a fill, so it is not counted as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            refill     <= 1'b0;
        end else begin
            if ((state == CHECK) && req && !hit && (miss_count != '1)) begin
                miss_count <= miss_count + COUNT_WIDTH'(1);
            end
            if (hit_resp && !refill && (hit_count != '1)) begin
                hit_count <= hit_count + COUNT_WIDTH'(1);
            end
            if ((state == ALLOCATE) && bus.pmem_resp) begin
                refill <= 1'b1;
            end else if (hit_resp) begin
                refill <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way set-associative write-back cache. It sequences the cache datapath per CPU access: hit detection, dirty-victim writeback, line allocation from physical memory, and the LRU, valid, dirty, tag and data array load strobes. It sits between the CPU memory port and the physical-memory port, driving the datapath's way-select and mux selects; the datapath decodes the per-way loads from `way_sel`.

## Interface

Parameters
- `COUNT_WIDTH`, default 16: width of each performance counter. Used only when `CACHE_PERF_COUNTERS_EN` is defined.

Ports
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  CPU read request, held until `mem_resp`.
- `mem_write`  in  1  CPU write request, held until `mem_resp`.
- `mem_resp`  out  1  CPU access complete.
- `hit0`, `hit1`  in  1 each  way tag match AND valid, for the indexed set.
- `dirty0`, `dirty1`  in  1 each  way dirty bits, for the indexed set.
- `lru`  in  1  LRU bit of the indexed set; the value is the victim way.
- `pmem_resp`  in  1  physical memory transfer done.
- `pmem_read`, `pmem_write`  out  1 each  physical memory strobes.
- `pmem_addr_sel`  out  1  0 = CPU address, 1 = victim tag plus set (writeback address).
- `way_sel`  out  1  way targeted by this cycle's array loads.
- `load_data`, `load_tag`, `load_valid`, `load_dirty`, `load_lru`  out  1 each  array write enables.
- `data_in_sel`  out  1  0 = CPU write-merge data, 1 = pmem line.
- `dirty_in`, `lru_in`  out  1 each  values written on `load_dirty` and `load_lru`.
- `hit_count`, `miss_count`  out  `COUNT_WIDTH` each  present only with `CACHE_PERF_COUNTERS_EN`.

## Operation

- States: CHECK (reset state), WRITEBACK, ALLOCATE. `state` is the only control register, plus the `refill` flag when counters are enabled.
- Request is `mem_read | mem_write`. If both are asserted, the access is treated as a write.
- Hit way is `hit1 ? 1 : 0`. Victim way is `lru`.
- CHECK with no request:
  - All outputs are 0.
  - Stay in CHECK.
- CHECK with request and `hit0 | hit1`:
  - `mem_resp=1`, `way_sel`=hit way.
  - `load_lru=1`, `lru_in`=~hit way.
  - On a write, additionally `load_data=1`, `data_in_sel=0`, `load_dirty=1`, `dirty_in=1`.
  - Stay in CHECK.
- CHECK with request and miss:
  - Go to WRITEBACK if the victim's dirty bit (`lru ? dirty1 : dirty0`) is 1, otherwise go to ALLOCATE.
  - No array loads occur this cycle.
- WRITEBACK:
  - `pmem_write=1`, `pmem_addr_sel=1`, `way_sel=lru`.
  - On `pmem_resp`, go to ALLOCATE.
- ALLOCATE:
  - `pmem_read=1`, `pmem_addr_sel=0`, `way_sel=lru`.
  - On `pmem_resp`, for one cycle: `load_data=1`, `data_in_sel=1`, `load_tag=1`, `load_valid=1`, `load_dirty=1`, `dirty_in=0`. Then go to CHECK.
  - The next CHECK cycle hits and completes the access.
- A request dropped mid-miss is illegal. The controller still completes the line fill.
- Outputs are combinational from `state` and inputs. `mem_resp` and the hit loads are Mealy outputs in CHECK.

## Timing

- Reset: state is CHECK and every output is 0 at once (asynchronous); counters are 0.
- Hit: `mem_resp` is asserted in the first cycle of the request, with 0 wait cycles.
- Clean miss: CHECK (1 cycle), then ALLOCATE (N cycles until `pmem_resp`), then CHECK hit. `mem_resp` arrives N+1 cycles after request start.
- Dirty miss: same as a clean miss plus M WRITEBACK cycles, so `mem_resp` arrives M+N+1 cycles after request start.
- `pmem_read`/`pmem_write` are held continuously until the `pmem_resp` cycle and drop the cycle after. They are never both 1.
- `rst` asserted during WRITEBACK or ALLOCATE drops the pmem strobes in the same cycle. No array load fires.
- A `pmem_resp` seen in CHECK is ignored.

## Configuration

- `CACHE_PERF_COUNTERS_EN` defined:
  - Adds the `hit_count` and `miss_count` ports and the `refill` flag register.
  - `miss_count` increments on each CHECK→WRITEBACK or CHECK→ALLOCATE transition.
  - `hit_count` increments on each `mem_resp` cycle where `refill=0`.
  - `refill` is set on ALLOCATE→CHECK and cleared on the next `mem_resp`, so the post-fill hit is not counted.
  - Both counters saturate at all-ones and clear on `rst`.
- `CACHE_PERF_COUNTERS_EN` undefined: the counter ports, logic and `refill` flag are absent. All other behaviour is identical.

## Test plan

- Read hit in way 1 (`hit1=1`, `lru=1`) -> same-cycle `mem_resp=1`, `way_sel=1`, `load_lru=1`, `lru_in=0`; no data load; `hit_count` 0→1.
- Write hit in way 0 -> same cycle: `load_data=1`, `data_in_sel=0`, `load_dirty=1`, `dirty_in=1`, `lru_in=1`, `mem_resp=1`.
- Clean read miss (`lru=0`, `dirty0=0`), with `pmem_resp` after 3 cycles -> `pmem_read` high 3 cycles; fill loads on `way_sel=0` with `dirty_in=0`; `mem_resp` on cycle 5; `miss_count=1`, `hit_count=0`.
- Dirty write miss (`lru=1`, `dirty1=1`), with writeback 2 cycles and fill 2 cycles -> `pmem_write`, `pmem_addr_sel=1` for 2 cycles; then `pmem_read` for 2 cycles; then CHECK write hit sets dirty; `mem_resp` on cycle 6.
- `rst` pulse in the middle of ALLOCATE -> `pmem_read` drops immediately; state is CHECK; no `load_valid` pulse; counters are 0.
- Counter saturation with `COUNT_WIDTH=2` and 5 hits -> `hit_count` stays at 3.
